// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch stage: PC register, req/ack instruction
//               memory fetch, valid/ready hand-off to decode, next-PC select.
//               Optional accept counter enabled by macro FETCH_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [5:0]  opcode,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic [31:0] imm,
    output logic        timeout,
    output logic [31:0] fetch_count
);

    localparam int              CW        = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0]   WAIT_LAST = CW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t          state;
    logic [CW-1:0]   wait_cnt;
    logic [31:0]     next_pc;
    logic            accept;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign opcode    = inst[31:26];
    assign accept    = (state == HOLD) && inst_ready;

    // Jump outranks a taken branch when both are reported together.
    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], inst[25:0], 2'b00};
        end else if (branch && zero) begin
            next_pc = pc_plus4 + (imm << 2);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            inst       <= 32'd0;
            wait_cnt   <= '0;
            imem_req   <= 1'b0;
            inst_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                end
                REQ: begin
                    if (imem_ack) begin
                        inst       <= imem_rdata;
                        imem_req   <= 1'b0;
                        inst_valid <= 1'b1;
                        state      <= HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        // This cycle brings the count to MAX_WAIT.
                        if (wait_cnt == WAIT_LAST) begin
                            imem_req <= 1'b0;
                            timeout  <= 1'b1;
                            state    <= ERR;
                        end
                    end
                end
                HOLD: begin
                    if (inst_ready) begin
                        pc         <= next_pc;
                        wait_cnt   <= '0;
                        inst_valid <= 1'b0;
                        imem_req   <= 1'b1;
                        state      <= REQ;
                    end
                end
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 32'd0;
        end else if (accept) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign fetch_count = count_q;
`else
    logic unused_accept;

    assign unused_accept = accept;
    assign fetch_count   = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Scoreboard bench for instr_fetch: randomized memory latency,
//               downstream stalls and branch/jump outcomes vs a PC model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam int          MW  = 15;
`ifdef FETCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_ack, inst_valid, inst_ready;
    logic [31:0] imem_addr, imem_rdata, inst, pc, pc_plus4, imm, fetch_count;
    logic [5:0]  opcode;
    logic        branch, zero, jump, timeout;

    instr_fetch #(.RESET_PC(RPC), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .opcode(opcode), .pc(pc), .pc_plus4(pc_plus4),
        .branch(branch), .zero(zero), .jump(jump), .imm(imm),
        .timeout(timeout), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic b; logic z; logic j; logic [31:0] imm; int wait_rdy; } ctl_t;
    typedef struct { logic [31:0] data; int delay; } mem_t;

    int          errors = 0;
    int          checks = 0;
    int          accepts = 0;
    bit          mem_dead = 1'b0;
    logic [31:0] addr_q[$];
    logic [31:0] inst_q[$];
    logic [31:0] req_log[$];
    ctl_t        ctl_q[$];
    mem_t        mem_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder: one fetch per new request, address checked against the model.
    initial begin : mem_proc
        bit          in_req;
        int          dly;
        logic [31:0] cur, dat;
        in_req = 1'b0; dly = 0; cur = 32'd0; dat = 32'd0;
        imem_ack = 1'b0; imem_rdata = 32'd0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                in_req   = 1'b0;
                imem_ack = 1'b0;
            end else if (imem_req) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    req_log.push_back(imem_addr);
                    if (addr_q.size() == 0) begin
                        check("unexpected_fetch", imem_addr, 32'hxxxx_xxxx);
                        cur = imem_addr;
                    end else begin
                        cur = addr_q.pop_front();
                        check("imem_addr", imem_addr, cur);
                    end
                    if (mem_q.size() > 0) begin
                        dly = mem_q[0].delay;
                        dat = mem_q[0].data;
                        void'(mem_q.pop_front());
                    end else begin
                        dly = $urandom_range(0, 3);
                        dat = $urandom;
                    end
                end else begin
                    check("imem_addr_stable", imem_addr, cur);
                end
                if (mem_dead) begin
                    imem_ack = 1'b0;
                end else if (dly == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = dat;
                    inst_q.push_back(dat);
                    in_req     = 1'b0;
                end else begin
                    dly--;
                    imem_ack   = 1'b0;
                    imem_rdata = $urandom;
                end
            end else begin
                imem_ack   = 1'($urandom_range(0, 1));
                imem_rdata = $urandom;
            end
        end
    end

    // Downstream consumer and monitor: owns the PC reference model.
    initial begin : ds_proc
        logic [31:0] mpc, ninst, npc, mpc4;
        ctl_t        c;
        bit          have_c, rdy;
        mpc = RPC; have_c = 1'b0;
        c = '{b: 1'b0, z: 1'b0, j: 1'b0, imm: 32'd0, wait_rdy: -1};
        inst_ready = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0; imm = 32'd0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                mpc = RPC;
                addr_q.delete();
                addr_q.push_back(RPC);
                inst_q.delete();
                inst_ready = 1'b0;
                have_c     = 1'b0;
                accepts    = 0;
            end else begin
                check("fetch_count", fetch_count, STATS ? 32'(accepts) : 32'd0);
                branch = 1'($urandom_range(0, 1));
                zero   = 1'($urandom_range(0, 1));
                jump   = 1'($urandom_range(0, 1));
                imm    = $urandom;
                if (inst_valid) begin
                    if (inst_q.size() == 0) begin
                        check("unexpected_valid", inst, 32'hxxxx_xxxx);
                        inst_ready = 1'b0;
                    end else begin
                        ninst = inst_q[0];
                        check("inst", inst, ninst);
                        check("opcode", {26'd0, opcode}, {26'd0, ninst[31:26]});
                        check("pc", pc, mpc);
                        check("pc_plus4", pc_plus4, mpc + 32'd4);
                        if (!have_c) begin
                            if (ctl_q.size() > 0) begin
                                c = ctl_q.pop_front();
                            end else begin
                                c.b = ($urandom_range(0, 2) == 0);
                                c.z = 1'($urandom_range(0, 1));
                                c.j = ($urandom_range(0, 3) == 0);
                                c.imm = 32'($urandom_range(0, 127)) - 32'd64;
                                c.wait_rdy = -1;
                            end
                            have_c = 1'b1;
                        end
                        if (c.wait_rdy >= 0) begin
                            rdy = (c.wait_rdy == 0);
                            if (c.wait_rdy > 0) c.wait_rdy--;
                        end else begin
                            rdy = ($urandom_range(0, 3) != 0);
                        end
                        inst_ready = rdy;
                        if (rdy) begin
                            branch = c.b; zero = c.z; jump = c.j; imm = c.imm;
                            mpc4 = mpc + 32'd4;
                            if (c.j)
                                npc = (mpc4 & 32'hF000_0000) + (ninst & 32'h03FF_FFFF) * 4;
                            else if (c.b && c.z)
                                npc = mpc4 + c.imm * 4;
                            else
                                npc = mpc4;
                            void'(inst_q.pop_front());
                            mpc = npc;
                            addr_q.push_back(npc);
                            accepts++;
                            have_c = 1'b0;
                        end
                    end
                end else begin
                    inst_ready = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    task automatic check_reset_values();
        check("rst_pc", pc, RPC);
        check("rst_imem_addr", imem_addr, RPC);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_timeout", {31'd0, timeout}, 32'd0);
        check("rst_fetch_count", fetch_count, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values();
        req_log.delete();
        rst = 1'b0;
        @(negedge clk);
        check("first_req_cycle2", {31'd0, imem_req}, 32'd1);
        check("first_req_addr", imem_addr, RPC);
    endtask

    task automatic wait_accepts(input int n, input int bound, input string name);
        int c;
        c = 0;
        while (accepts < n && c < bound) begin
            @(negedge clk);
            c++;
        end
        check(name, 32'(accepts >= n), 32'd1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] LW   = 32'h8C08_0004;
    localparam logic [31:0] BEQ  = 32'h1000_FFFE;
    localparam logic [31:0] JMP  = 32'h0800_0040;

    initial begin : main
        logic [31:0] exp_addrs[10];
        int          n;
        exp_addrs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'hC, 32'h10, 32'h14,
                      32'h1000_0000, 32'h1000_0100};

        // Directed program: lw run, stalled beq taken/not-taken, far branch, jump.
        for (int i = 0; i < 4; i++) begin
            mem_q.push_back('{data: LW, delay: 0});
            ctl_q.push_back('{b: 1'b0, z: 1'b0, j: 1'b0, imm: 32'd0, wait_rdy: 0});
        end
        mem_q.push_back('{data: BEQ, delay: 3});
        ctl_q.push_back('{b: 1'b1, z: 1'b1, j: 1'b0, imm: 32'hFFFF_FFFE, wait_rdy: 2});
        mem_q.push_back('{data: LW, delay: 0});
        ctl_q.push_back('{b: 1'b0, z: 1'b0, j: 1'b0, imm: 32'd0, wait_rdy: 0});
        mem_q.push_back('{data: BEQ, delay: 0});
        ctl_q.push_back('{b: 1'b1, z: 1'b0, j: 1'b0, imm: 32'hFFFF_FFFE, wait_rdy: 0});
        mem_q.push_back('{data: BEQ, delay: 0});
        ctl_q.push_back('{b: 1'b1, z: 1'b1, j: 1'b0, imm: 32'h03FF_FFFA, wait_rdy: 0});
        mem_q.push_back('{data: JMP, delay: 0});
        ctl_q.push_back('{b: 1'b1, z: 1'b1, j: 1'b1, imm: 32'hFFFF_FFFE, wait_rdy: 0});
        mem_q.push_back('{data: LW, delay: 0});

        do_reset();
        wait_accepts(9, 300, "directed_accepts");
        n = 0;
        while (req_log.size() < 10 && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            check($sformatf("req_addr_%0d", i),
                  (i < req_log.size()) ? req_log[i] : 32'hxxxx_xxxx, exp_addrs[i]);
        end

        // Randomized traffic against the model.
        wait_accepts(160, 5000, "random_accepts");

        // Accept counter, then reset in the middle of a request.
        do_reset();
        wait_accepts(5, 300, "stats_accepts");
        n = 0;
        while (!imem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_before_reset", {31'd0, imem_req}, 32'd1);
        check("fetch_count_before_reset", fetch_count, STATS ? 32'd5 : 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values();

        // Memory never answers.
        mem_dead = 1'b1;
        do_reset();
        n = 0;
        while (!timeout && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency", 32'(n), 32'(MW));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("err_imem_req", {31'd0, imem_req}, 32'd0);
            check("err_inst_valid", {31'd0, inst_valid}, 32'd0);
            check("err_timeout_sticky", {31'd0, timeout}, 32'd1);
        end
        mem_dead = 1'b0;
        do_reset();
        wait_accepts(3, 100, "recover_accepts");

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
